hex_number_entry: RTL and testbench

Keyboard-side counterpart of the board's static hex display path on the DE10-Lite. It turns the two raw push-buttons and the low switches into the 24-bit value that the six seven-segment digits show. It synchronises and debounces both keys, then lets the user write hex digits one at a time with a visible cursor. Its `number` output feeds the per-digit display decoders directly, and its `dp_n` output drives the decimal points.

---
 rtl/hex_entry_pkg.sv | 6 +
 rtl/key_debouncer.sv | 60 ++++++
 rtl/hex_number_entry.sv | 140 ++++++++++++++
 tb/tb_hex_number_entry.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex number entry block.
package hex_entry_pkg;
  typedef logic [3:0] digit_t;
  typedef logic [2:0] cursor_t;
  localparam int DEFAULT_N_DIGITS = 6;
endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and one-cycle press pulse for an active-low key.
// With HEX_ENTRY_AUTO_REPEAT_EN defined it also exports o_hold for the top-level repeat logic.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
`ifdef HEX_ENTRY_AUTO_REPEAT_EN
  output logic o_hold,
`endif
  output logic o_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_sync_vld;
  logic             r_armed;
  logic             r_db;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign w_accept = (r_sync2 != r_db) && (r_cnt == CNT_LAST);

  // r_armed blocks the pulse for a key that was already down when reset released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
      r_db       <= 1'b1;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && r_sync2)
        r_armed <= 1'b1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= '0;
        r_db  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_press <= w_accept && !r_sync2 && r_armed;
    end
  end

  assign o_press = r_press;
`ifdef HEX_ENTRY_AUTO_REPEAT_EN
  assign o_hold  = !r_db && !w_accept;
`endif
endmodule

// File: rtl/hex_number_entry.sv
// Hex digit entry with cursor for the six-digit display: key[0] writes sw, key[1] moves left.
// Optional macro HEX_ENTRY_AUTO_REPEAT_EN adds auto-repeat on a held key[1].
module hex_number_entry
  import hex_entry_pkg::*;
#(
  parameter int N_DIGITS        = DEFAULT_N_DIGITS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            key,
  input  logic [3:0]            sw,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] number,
  output cursor_t               cursor,
  output logic [N_DIGITS-1:0]   dp_n,
  output logic [1:0]            press
);
  localparam cursor_t               CUR_LAST = cursor_t'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0]   DP_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [N_DIGITS-1:0]   DP_RST   = ~(DP_ONE << (N_DIGITS - 1));

  if (N_DIGITS < 2 || N_DIGITS > 8 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("hex_number_entry: parameter out of range");
  end

  logic [1:0]                w_db_press;
  logic                      w_p0;
  logic                      w_p1;
  digit_t [N_DIGITS-1:0]     r_number;
  cursor_t                   r_cursor;
  logic [N_DIGITS-1:0]       r_dp_n;
  digit_t [N_DIGITS-1:0]     w_number_nxt;
  cursor_t                   w_cursor_nxt;
  logic [N_DIGITS-1:0]       w_dp_nxt;

`ifdef HEX_ENTRY_AUTO_REPEAT_EN
  logic [1:0] w_db_hold;
`endif

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_key_n (key[k]),
`ifdef HEX_ENTRY_AUTO_REPEAT_EN
      .o_hold  (w_db_hold[k]),
`endif
      .o_press (w_db_press[k])
    );
  end

  assign w_p0 = w_db_press[0];

`ifdef HEX_ENTRY_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;
  logic             r_rpt_held;
  logic             r_rpt_pulse;
  logic             w_rpt_active;
  logic [RPT_W-1:0] w_rpt_last;

  // Repeat only follows a genuine press, and stops on the edge the debounced release lands
  assign w_rpt_active = (r_rpt_held || w_db_press[1]) && w_db_hold[1];
  assign w_rpt_last   = r_rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
      r_rpt_held  <= 1'b0;
      r_rpt_pulse <= 1'b0;
    end else begin
      r_rpt_held  <= w_rpt_active;
      r_rpt_pulse <= 1'b0;
      if (!w_rpt_active) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b1;
      end else if (r_rpt_cnt == w_rpt_last) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b0;
        r_rpt_pulse <= 1'b1;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + 1'b1;
      end
    end
  end

  assign w_p1 = w_db_press[1] || r_rpt_pulse;
`else
  assign w_p1 = w_db_press[1];
`endif

  always_comb begin
    w_number_nxt = r_number;
    w_cursor_nxt = r_cursor;
    if (clear) begin
      w_number_nxt = '0;
      w_cursor_nxt = CUR_LAST;
    end else begin
      if (w_p0) begin
        for (int i = 0; i < N_DIGITS; i++)
          if (r_cursor == cursor_t'(i))
            w_number_nxt[i] = sw;
      end
      // Both keys together: write only, cursor stays
      case ({w_p1, w_p0})
        2'b01:   w_cursor_nxt = (r_cursor == '0) ? CUR_LAST : r_cursor - 3'd1;
        2'b10:   w_cursor_nxt = (r_cursor == CUR_LAST) ? '0 : r_cursor + 3'd1;
        default: w_cursor_nxt = r_cursor;
      endcase
    end
    w_dp_nxt = ~(DP_ONE << w_cursor_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_number <= '0;
      r_cursor <= CUR_LAST;
      r_dp_n   <= DP_RST;
    end else begin
      r_number <= w_number_nxt;
      r_cursor <= w_cursor_nxt;
      r_dp_n   <= w_dp_nxt;
    end
  end

  assign number = r_number;
  assign cursor = r_cursor;
  assign dp_n   = r_dp_n;
  assign press  = {w_p1, w_p0};
endmodule

// File: tb/tb_hex_number_entry.sv
// Self-checking bench for hex_number_entry: vector table for digit entry, scoreboard for press pulses.
module tb_hex_number_entry;
  localparam int N  = 6;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  key = 2'b11;
  logic [3:0]  sw = 4'h0;
  logic        clear = 1'b0;
  logic [23:0] number;
  logic [2:0]  cursor;
  logic [5:0]  dp_n;
  logic [1:0]  press;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  typedef struct {
    int         edge_n;
    logic [1:0] bits;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [1:0]  mask;
    logic [3:0]  v;
    logic [23:0] num;
    logic [2:0]  cur;
  } vec_t;
  vec_t tbl[11];

  hex_number_entry #(
    .N_DIGITS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .sw(sw), .clear(clear),
    .number(number), .cursor(cursor), .dp_n(dp_n), .press(press)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(string tag, logic [23:0] num, logic [2:0] cur);
    logic [5:0] exp_dp;
    exp_dp = ~(6'b000001 << cur);
    check({tag, "_number"}, 32'(number), 32'(num));
    check({tag, "_cursor"}, 32'(cursor), 32'(cur));
    check({tag, "_dp_n"},   32'(dp_n),   32'(exp_dp));
  endtask

  // Press monitor: every pulse must match the head of the scoreboard, on the expected edge
  always @(posedge clk) begin
    ev_t e;
    ecount++;
    #1;
    if (press !== 2'b00) begin
      if (sb.size() == 0) begin
        check("press_unexpected", 32'(press), 32'd0);
      end else begin
        e = sb.pop_front();
        check("press_edge", ecount, e.edge_n);
        check("press_bits", 32'(press), 32'(e.bits));
      end
    end else if (sb.size() != 0 && ecount > sb[0].edge_n) begin
      e = sb.pop_front();
      check("press_missing", ecount, e.edge_n);
    end
  end

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press(logic [1:0] mask, logic [3:0] v, int hold);
    int s;
    @(negedge clk);
    sw  = v;
    key = ~mask;
    s   = ecount + 1;
    sb.push_back('{s + D + 1, mask});
    wait_neg(hold);
    key = 2'b11;
    wait_neg(2 * D + 6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(5);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int guard;
    logic [2:0] rpt_cur;

    tbl[0]  = '{2'b01, 4'hA, 24'hA00000, 3'd4};
    tbl[1]  = '{2'b01, 4'h3, 24'hA30000, 3'd3};
    tbl[2]  = '{2'b10, 4'h0, 24'hA30000, 3'd4};
    tbl[3]  = '{2'b10, 4'h0, 24'hA30000, 3'd5};
    tbl[4]  = '{2'b10, 4'h0, 24'hA30000, 3'd0};
    tbl[5]  = '{2'b01, 4'h5, 24'hA30005, 3'd5};
    tbl[6]  = '{2'b01, 4'hF, 24'hF30005, 3'd4};
    tbl[7]  = '{2'b01, 4'h1, 24'hF10005, 3'd3};
    tbl[8]  = '{2'b01, 4'h2, 24'hF12005, 3'd2};
    tbl[9]  = '{2'b11, 4'h7, 24'hF12705, 3'd2};
    tbl[10] = '{2'b01, 4'h9, 24'hF12905, 3'd1};

    wait_neg(3);
    check_state("in_reset", 24'h0, 3'd5);
    check("in_reset_press", 32'(press), 32'd0);
    reset_n = 1'b1;
    wait_neg(5);
    check_state("reset", 24'h0, 3'd5);
    check("reset_press", 32'(press), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_press(tbl[i].mask, tbl[i].v, 10);
      check_state($sformatf("vec%0d", i), tbl[i].num, tbl[i].cur);
    end

    // Short glitches on key[1] must never be accepted
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key = 2'b01;
      wait_neg(3);
      key = 2'b11;
      wait_neg(3);
    end
    wait_neg(10);
    check_state("bounce", 24'h0, 3'd5);
    do_press(2'b10, 4'h0, 10);
    check_state("bounce_wrap", 24'h0, 3'd0);
    do_press(2'b01, 4'hC, 10);
    check_state("write_wrap", 24'h00000C, 3'd5);

    // Clear on the exact edge where the key[0] action lands
    @(negedge clk);
    sw  = 4'hE;
    key = 2'b10;
    s   = ecount + 1;
    sb.push_back('{s + D + 1, 2'b01});
    guard = 0;
    while (ecount < s + D + 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("clear_sync", ecount, s + D + 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_neg(5);
    key = 2'b11;
    wait_neg(2 * D + 6);
    check_state("clear_prio", 24'h0, 3'd5);

    // Long hold on key[1]
    @(negedge clk);
    key = 2'b01;
    s   = ecount + 1;
    sb.push_back('{s + D + 1, 2'b10});
`ifdef HEX_ENTRY_AUTO_REPEAT_EN
    for (int t = s + D + 1 + RD; t < s + 60; t += RP)
      sb.push_back('{t, 2'b10});
    rpt_cur = 3'd5;
`else
    rpt_cur = 3'd0;
`endif
    wait_neg(30);
`ifdef HEX_ENTRY_AUTO_REPEAT_EN
    check_state("repeat_mid", 24'h0, 3'd1);
`else
    check_state("repeat_mid", 24'h0, 3'd0);
`endif
    wait_neg(30);
    key = 2'b11;
    wait_neg(2 * D + 20);
    check_state("repeat_end", 24'h0, rpt_cur);

    // Key held across reset release gives no pulse until re-pressed
    do_press(2'b01, 4'h4, 10);
    @(negedge clk);
    sw  = 4'h6;
    key = 2'b10;
    wait_neg(3);
    reset_n = 1'b0;
    wait_neg(1);
    check_state("mid_reset", 24'h0, 3'd5);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(20);
    check_state("held_through_reset", 24'h0, 3'd5);
    key = 2'b11;
    wait_neg(2 * D + 6);
    do_press(2'b01, 4'h6, 10);
    check_state("after_rearm", 24'h600000, 3'd4);

    wait_neg(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
